// File: rtl/io_pad_bank_if.sv
// Signal bundle between a shared pad bank arbiter, its two requesters and the pad cells.
// The slave modport is the arbiter's view. The master modport is the requester/pad side.
`timescale 1ns/1ps
interface io_pad_bank_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic [WIDTH-1:0] d_out0;
   logic [WIDTH-1:0] oe0;
   logic [WIDTH-1:0] d_out1;
   logic [WIDTH-1:0] oe1;
   logic [WIDTH-1:0] c2p;
   logic [WIDTH-1:0] c2p_en;
   logic [WIDTH-1:0] p2c;
   logic [WIDTH-1:0] p2c_sync;
   logic             busy;

   modport slave (
      input  req, d_out0, oe0, d_out1, oe1, p2c,
      output gnt, c2p, c2p_en, p2c_sync, busy
   );

   modport master (
      output req, d_out0, oe0, d_out1, oe1, p2c,
      input  gnt, c2p, c2p_en, p2c_sync, busy
   );
endinterface

// File: rtl/io_pad_bank_arbiter.sv
// Round-robin owner arbitration for one shared pad bank. It inserts a tristate turnaround
// on every release and provides a two-flop synchroniser on the pad input path.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | no owner, pads tristated, arbitrate req using last owner
//  GRANT0 | core function (requester 0) owns the pads
//  GRANT1 | debug/test (requester 1) owns the pads
//  TURN   | turnaround after a release, all enables low for TURN_CYCLES
`timescale 1ns/1ps
module io_pad_bank_arbiter #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2    // legal range 1..15
) (
   input  logic           clk,
   input  logic           rst_n,
   io_pad_bank_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      TURN   = 2'd3
   } state_t;

   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

   state_t           state;
   logic [1:0]       gnt_q;
   logic             last;
   logic [3:0]       turn_cnt;
   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt_q    <= 2'b00;
         last     <= 1'b1;
         turn_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               // on a tie, the requester that did not own the bank last wins
               if (bus.req[0] && (!bus.req[1] || last)) begin
                  state <= GRANT0;
                  gnt_q <= 2'b01;
                  last  <= 1'b0;
               end else if (bus.req[1]) begin
                  state <= GRANT1;
                  gnt_q <= 2'b10;
                  last  <= 1'b1;
               end
            end
            GRANT0: begin
               if (!bus.req[0]) begin
                  state    <= TURN;
                  gnt_q    <= 2'b00;
                  turn_cnt <= TURN_LOAD;
               end
            end
            GRANT1: begin
               if (!bus.req[1]) begin
                  state    <= TURN;
                  gnt_q    <= 2'b00;
                  turn_cnt <= TURN_LOAD;
               end
            end
            TURN: begin
               if (turn_cnt != 4'd0) begin
                  turn_cnt <= turn_cnt - 4'd1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               gnt_q <= 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= bus.p2c;
         sync_out  <= sync_meta;
      end
   end

   // Decoded from state alone, so an async reset drops the pad enables at once
   always_comb begin
      bus.c2p    = '0;
      bus.c2p_en = '0;
      case (state)
         GRANT0: begin
            bus.c2p    = bus.d_out0;
            bus.c2p_en = bus.oe0;
         end
         GRANT1: begin
            bus.c2p    = bus.d_out1;
            bus.c2p_en = bus.oe1;
         end
         default: begin
            bus.c2p    = '0;
            bus.c2p_en = '0;
         end
      endcase
   end

   assign bus.gnt      = gnt_q;
   assign bus.busy     = (state != IDLE);
   assign bus.p2c_sync = sync_out;

endmodule

// File: tb/tb_io_pad_bank_arbiter.sv
// Bench for io_pad_bank_arbiter: directed arbitration/turnaround checks, a scoreboard on the
// input synchroniser, and turnaround-length corners at TURN_CYCLES = 1 and 15.
`timescale 1ns/1ps
module tb_io_pad_bank_arbiter;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_sys = ~clk_sys;

   io_pad_bank_if #(.WIDTH(8)) bus   ();
   io_pad_bank_if #(.WIDTH(8)) bus1  ();
   io_pad_bank_if #(.WIDTH(8)) bus15 ();

   io_pad_bank_arbiter #(.WIDTH(8), .TURN_CYCLES(2))  u_dut   (.clk(clk_sys), .rst_n(rst_n), .bus(bus));
   io_pad_bank_arbiter #(.WIDTH(8), .TURN_CYCLES(1))  u_dut1  (.clk(clk_sys), .rst_n(rst_n), .bus(bus1));
   io_pad_bank_arbiter #(.WIDTH(8), .TURN_CYCLES(15)) u_dut15 (.clk(clk_sys), .rst_n(rst_n), .bus(bus15));

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] val;
      int         due;
   } sb_t;
   sb_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #2;
   endtask

   // Value driven now is captured on the next edge and appears after the one after it
   task automatic drive_p2c(input logic [7:0] v);
      sb_t e;
      bus.p2c = v;
      e.val   = v;
      e.due   = cyc + 2;
      sb_q.push_back(e);
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         sb_t e;
         e = sb_q.pop_front();
         chk("p2c_sync_sb", 32'(bus.p2c_sync), 32'(e.val));
      end
   end

   // Enables must always belong to the current grant holder, or be low
   always @(negedge clk_sys) begin
      if (bus.gnt == 2'b00)
         chk("en_while_ungranted", 32'(bus.c2p_en), 32'h0);
      else if (bus.gnt == 2'b01)
         chk("en_owner0", 32'(bus.c2p_en), 32'(bus.oe0));
      else if (bus.gnt == 2'b10)
         chk("en_owner1", 32'(bus.c2p_en), 32'(bus.oe1));
      else
         chk("gnt_onehot", 32'(bus.gnt), 32'h1);
   end

   initial begin
      int t1, t15, bad1, bad15;
      bus.req = 2'b11;   bus.d_out0 = 8'hFF; bus.oe0 = 8'hFF;
      bus.d_out1 = 8'h00; bus.oe1 = 8'h00;   bus.p2c = 8'h5A;
      bus1.req = 2'b00;  bus1.d_out0 = 8'h11; bus1.oe0 = 8'hFF;
      bus1.d_out1 = 8'h22; bus1.oe1 = 8'hFF; bus1.p2c = 8'h00;
      bus15.req = 2'b00; bus15.d_out0 = 8'h33; bus15.oe0 = 8'hFF;
      bus15.d_out1 = 8'h44; bus15.oe1 = 8'hFF; bus15.p2c = 8'h00;

      // reset held with both requesting
      repeat (3) step();
      chk("rst_gnt",      32'(bus.gnt),      32'h0);
      chk("rst_c2p_en",   32'(bus.c2p_en),   32'h0);
      chk("rst_c2p",      32'(bus.c2p),      32'h0);
      chk("rst_p2c_sync", 32'(bus.p2c_sync), 32'h0);
      chk("rst_busy",     32'(bus.busy),     32'h0);

      // single grant
      rst_n = 1'b1;
      bus.req = 2'b01; bus.d_out0 = 8'hA5; bus.oe0 = 8'h0F;
      drive_p2c(8'h00);
      step();
      chk("single_gnt",    32'(bus.gnt),    32'h1);
      chk("single_c2p",    32'(bus.c2p),    32'hA5);
      chk("single_c2p_en", 32'(bus.c2p_en), 32'h0F);
      chk("single_busy",   32'(bus.busy),   32'h1);

      // turnaround to requester 1
      bus.req = 2'b11; bus.d_out1 = 8'hC3; bus.oe1 = 8'hF0;
      step();
      chk("gnt_hold", 32'(bus.gnt), 32'h1);
      bus.req = 2'b10;
      step();
      chk("turn1_gnt",  32'(bus.gnt),    32'h0);
      chk("turn1_en",   32'(bus.c2p_en), 32'h0);
      chk("turn1_busy", 32'(bus.busy),   32'h1);
      drive_p2c(8'h3C);
      step();
      chk("turn2_gnt",  32'(bus.gnt),      32'h0);
      chk("turn2_en",   32'(bus.c2p_en),   32'h0);
      chk("turn2_busy", 32'(bus.busy),     32'h1);
      chk("sync_1edge", 32'(bus.p2c_sync), 32'h00);
      step();
      chk("idle_gnt",  32'(bus.gnt),  32'h0);
      chk("idle_busy", 32'(bus.busy), 32'h0);
      step();
      chk("gnt1",        32'(bus.gnt),    32'h2);
      chk("gnt1_c2p",    32'(bus.c2p),    32'hC3);
      chk("gnt1_c2p_en", 32'(bus.c2p_en), 32'hF0);

      // per-pad enables pass through while owned
      bus.oe1 = 8'h3C; bus.d_out1 = 8'h5A;
      step();
      chk("perpad_en",  32'(bus.c2p_en), 32'h3C);
      chk("perpad_c2p", 32'(bus.c2p),    32'h5A);

      // async reset mid-GRANT
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_en",   32'(bus.c2p_en), 32'h0);
      chk("async_rst_gnt",  32'(bus.gnt),    32'h0);
      chk("async_rst_busy", 32'(bus.busy),   32'h0);
      bus.req = 2'b00; bus.oe0 = 8'hFF; bus.oe1 = 8'hFF;
      step();
      rst_n = 1'b1;
      step();

      // round-robin
      bus.req = 2'b11;
      step();
      chk("rr_first", 32'(bus.gnt), 32'h1);
      bus.req = 2'b10;
      step();
      chk("rr_turn_a", 32'(bus.gnt), 32'h0);
      bus.req = 2'b11;
      step();
      step();
      chk("rr_idle_a", 32'(bus.gnt), 32'h0);
      step();
      chk("rr_second", 32'(bus.gnt), 32'h2);
      bus.req = 2'b01;
      step();
      chk("rr_turn_b", 32'(bus.gnt), 32'h0);
      bus.req = 2'b11;
      step();
      step();
      step();
      chk("rr_third", 32'(bus.gnt), 32'h1);
      bus.req = 2'b00;
      step();

      // random traffic through the synchroniser
      for (int i = 0; i < 16; i++) begin
         drive_p2c(8'($urandom));
         step();
      end
      repeat (4) step();
      chk("sb_drain", 32'(sb_q.size()), 32'h0);

      // turnaround length corners
      bus1.req = 2'b01; bus15.req = 2'b01;
      step();
      chk("tc1_gnt",  32'(bus1.gnt),  32'h1);
      chk("tc15_gnt", 32'(bus15.gnt), 32'h1);
      bus1.req = 2'b00; bus15.req = 2'b00;
      t1 = 0; t15 = 0; bad1 = 0; bad15 = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus1.busy && bus1.gnt == 2'b00) t1++;
         if (bus15.busy && bus15.gnt == 2'b00) t15++;
         if (bus1.gnt == 2'b00 && bus1.c2p_en != 8'h00) bad1++;
         if (bus15.gnt == 2'b00 && bus15.c2p_en != 8'h00) bad15++;
      end
      chk("tc1_turn_cycles",  32'(t1),    32'd1);
      chk("tc15_turn_cycles", 32'(t15),   32'd15);
      chk("tc1_en_low",       32'(bad1),  32'd0);
      chk("tc15_en_low",      32'(bad15), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/io_pad_bank_arbiter.md
Name: io_pad_bank_arbiter

Overview:
- Shares one bank of WIDTH bidirectional I/O pads between two on-chip requesters: 0 = core function, 1 = debug/test.
- Grants pad ownership round-robin, muxes the owner's output data and output-enable onto the pad cells, and synchronises pad input data back into the core.
- On every owner change, inserts a programmable tristate turnaround so the two requesters never drive the pads back-to-back.
- Sits between the core and the IOLib pad cells, one instance per shared pad bank.

Parameters:
- WIDTH, 8, number of pads in the bank.
- TURN_CYCLES, 2, turnaround cycles with all pad enables forced low after a release; legal range 1..15.

Ports:
- clk  input  1  bank clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  request per requester; level, held high for as long as ownership is wanted.
- gnt  output  2  one-hot-or-zero grant, registered.
- d_out0  input  WIDTH  requester 0 pad output data.
- oe0  input  WIDTH  requester 0 per-pad output enable.
- d_out1  input  WIDTH  requester 1 pad output data.
- oe1  input  WIDTH  requester 1 per-pad output enable.
- c2p  output  WIDTH  data to pad cells.
- c2p_en  output  WIDTH  output enable to pad cells.
- p2c  input  WIDTH  raw data from pad input cells; asynchronous.
- p2c_sync  output  WIDTH  p2c after a two-flop synchroniser, broadcast to both requesters.
- busy  output  1  high in GRANT or TURN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, gnt=2'b00, last=1 (so requester 0 wins the first tie), turnaround counter=0, sync flops=0.
  - Consequently c2p=0, c2p_en=0, p2c_sync=0, busy=0.
  - Reset assertion forces c2p_en low immediately (asynchronously), including mid-GRANT or mid-TURN.
- State machine; req is sampled on the rising clk edge:
  - IDLE: if no req bit is set, stay. If exactly one is set, go to GRANT(that requester). If both are set, grant the requester != last. On entry to GRANT, gnt[owner]=1 and last=owner.
  - GRANT(o): stay while req[o]=1, regardless of the other requester. When req[o]=0, go to TURN, clear gnt and load the counter with TURN_CYCLES-1.
  - TURN: count down. While counter != 0, decrement and stay. At 0, go to IDLE. Requests arriving during TURN are held off and are arbitrated in IDLE.
- Grant latency:
  - req rising in IDLE -> gnt high on the next edge (1 cycle).
  - Release -> earliest next grant after TURN_CYCLES+1 cycles (TURN_CYCLES in TURN, 1 in IDLE).
- Pad mux:
  - Combinational from the registered state only; no dependency on req.
  - GRANT(0): c2p=d_out0, c2p_en=oe0.
  - GRANT(1): c2p=d_out1, c2p_en=oe1.
  - IDLE or TURN: c2p=0, c2p_en=0.
- Per-pad enables pass through unchanged: pads with oeX=0 stay input even while owned.
- gnt dropping and c2p_en going low happen on the same edge. There is no cycle with c2p_en driven by a requester whose gnt is low.
- Input path: p2c -> flop -> flop -> p2c_sync, 2-cycle latency, updated in every state (inputs stay observable while pads are tristated).
- Simultaneous events:
  - Owner drops req on the same edge the other raises it -> TURN, then grant the other.
  - Both drop and re-raise during TURN -> round-robin in IDLE using last.
- Requester protocol: a requester must not drop and re-raise req inside a single cycle to retain ownership. Any 0 sample releases ownership.
- busy = (state != IDLE).

Test Plan:
- Reset: hold rst_n=0 with req=2'b11, oe0=all ones -> gnt=0, c2p_en=0, p2c_sync=0. Assert rst_n=0 mid-GRANT -> c2p_en=0 before the next clk edge.
- Single grant: req=2'b01, d_out0=8'hA5, oe0=8'h0F -> gnt=2'b01 after 1 cycle, c2p=8'hA5, c2p_en=8'h0F, busy=1.
- Turnaround:
  - While requester 0 owns the bank, raise req[1]. Then drop req[0] -> gnt=0 and c2p_en=0 for exactly 2 cycles (TURN_CYCLES=2).
  - Then 1 IDLE cycle, then gnt=2'b10 with c2p=d_out1.
  - No cycle has c2p_en from either requester while gnt=0.
- Round-robin: from reset, req=2'b11 -> grant 0. Release 0 and re-raise it in TURN -> next grant 1. Release 1 with both still requesting -> next grant 0.
- Synchroniser: toggle p2c 8'h00 -> 8'h3C while in TURN -> p2c_sync=8'h3C exactly 2 edges later.
- Parameter corner: with TURN_CYCLES=1, release -> exactly 1 TURN cycle. With TURN_CYCLES=15, exactly 15 TURN cycles with c2p_en=0.
